// File: rtl/hs_fifo.sv
// Multi-entry valid/ready FIFO with occupancy count and almost-full flag.
// Define HS_FIFO_BYPASS_EN for a zero-latency pass-through path when the FIFO is empty.
module hs_fifo #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned AF_LEVEL = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       v_in,
  output logic                       r_out,
  output logic [WIDTH-1:0]           data_out,
  output logic                       v_out,
  input  logic                       r_in,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_full
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             empty;
  logic             full;
  logic             push;
  logic             pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  // Outputs are forced to their reset values for the whole reset cycle.
  assign r_out       = ~full & ~reset;
  assign count       = reset ? '0 : count_q;
  assign almost_full = ~reset & (count_q >= CW'(AF_LEVEL));
  assign pop         = ~reset & ~empty & r_in;

`ifdef HS_FIFO_BYPASS_EN
  logic pass;

  // An empty FIFO presents the incoming word directly; it is stored only if not taken.
  assign pass     = ~reset & empty & v_in & r_in;
  assign v_out    = ~reset & (~empty | v_in);
  assign data_out = reset ? '0 : (~empty ? mem[rd_ptr] : (v_in ? data_in : '0));
  assign push     = v_in & r_out & ~pass;
`else
  assign v_out    = ~reset & ~empty;
  assign data_out = v_out ? mem[rd_ptr] : '0;
  assign push     = v_in & r_out;
`endif

  // Pointer and occupancy state; wrap is an explicit compare so DEPTH need not be 2^n.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is not reset; it is only visible while v_out is high.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= data_in;
    end
  end

endmodule

// File: tb/tb_hs_fifo.sv
// Self-checking bench for hs_fifo: directed vector table, corner sequences and
// randomized traffic checked against a queue-based reference model.
module tb_hs_fifo;

  localparam int unsigned WIDTH    = 4;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned AF_LEVEL = 3;
  localparam int unsigned CW       = $clog2(DEPTH + 1);

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] data_in;
  logic             v_in;
  logic             r_out;
  logic [WIDTH-1:0] data_out;
  logic             v_out;
  logic             r_in;
  logic [CW-1:0]    count;
  logic             almost_full;

  hs_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL)) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .v_in       (v_in),
    .r_out      (r_out),
    .data_out   (data_out),
    .v_out      (v_out),
    .r_in       (r_in),
    .count      (count),
    .almost_full(almost_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       v;
    logic [3:0] d;
    logic       r;
    logic       ev;
    logic [3:0] ed;
    logic       er;
    int         ec;
    logic       eaf;
  } vec_t;

  vec_t       tbl[$];
  logic [WIDTH-1:0] model_q[$];
  int         n_cmp = 0;
  int         n_err = 0;

  task automatic cmp(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic rst, input logic v, input int d, input logic r,
                     input logic ev, input int ed, input logic er, input int ec, input logic eaf);
    vec_t t;
    t.rst = rst; t.v = v; t.d = 4'(d); t.r = r;
    t.ev = ev; t.ed = 4'(ed); t.er = er; t.ec = ec; t.eaf = eaf;
    tbl.push_back(t);
  endtask

  // Reference predictions for the current cycle, from queue contents and inputs.
  task automatic model_expect(output logic ev, output int ed, output logic er,
                              output int ec, output logic eaf);
    int sz;
    sz  = model_q.size();
    er  = !reset && (sz != DEPTH);
    ec  = reset ? 0 : sz;
    eaf = !reset && (sz >= AF_LEVEL);
    ev  = !reset && (sz != 0);
    ed  = ev ? int'(model_q[0]) : 0;
`ifdef HS_FIFO_BYPASS_EN
    if (!reset && sz == 0 && v_in) begin
      ev = 1'b1;
      ed = int'(data_in);
    end
`endif
  endtask

  task automatic model_update();
    int  sz;
    logic do_push;
    logic do_pop;
    sz = model_q.size();
    if (reset) begin
      model_q.delete();
    end else begin
      do_push = v_in && (sz != DEPTH);
      do_pop  = (sz != 0) && r_in;
`ifdef HS_FIFO_BYPASS_EN
      if (sz == 0 && v_in && r_in) do_push = 1'b0;
`endif
      if (do_pop) void'(model_q.pop_front());
      if (do_push) model_q.push_back(data_in);
    end
  endtask

  task automatic check_model(input string tag);
    logic ev, er, eaf;
    int   ed, ec;
    model_expect(ev, ed, er, ec, eaf);
    cmp({tag, ".v_out"}, int'(v_out), int'(ev));
    cmp({tag, ".data_out"}, int'(data_out), ed);
    cmp({tag, ".r_out"}, int'(r_out), int'(er));
    cmp({tag, ".count"}, int'(count), ec);
    cmp({tag, ".almost_full"}, int'(almost_full), int'(eaf));
  endtask

  // Drive one cycle: inputs after the edge, check at negedge, advance model on posedge.
  task automatic cycle(input logic rst, input logic v, input logic [WIDTH-1:0] d,
                       input logic r, input string tag);
    reset = rst; v_in = v; data_in = d; r_in = r;
    @(negedge clk);
    check_model(tag);
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    reset = 1'b1; v_in = 1'b1; data_in = '0; r_in = 1'b0;
    @(posedge clk);
    #1;

    // reset held with v_in high, then release
    add(1,1,5,0, 0,0,0,0,0);
    add(1,1,5,0, 0,0,0,0,0);
    add(0,0,0,0, 0,0,1,0,0);
    // fill to full with consumer stalled; fifth push dropped
    add(0,1,1,0, 0,0,1,0,0);
    add(0,1,2,0, 1,1,1,1,0);
    add(0,1,3,0, 1,1,1,2,0);
    add(0,1,4,0, 1,1,1,3,1);
    add(0,1,5,0, 1,1,0,4,1);
    add(0,0,0,0, 1,1,0,4,1);
    // drain in order
    add(0,0,0,1, 1,1,0,4,1);
    add(0,0,0,1, 1,2,1,3,1);
    add(0,0,0,1, 1,3,1,2,0);
    add(0,0,0,1, 1,4,1,1,0);
    add(0,0,0,0, 0,0,1,0,0);
    // streaming, pointers wrap
    add(0,1,0,1, 0,0,1,0,0);
    for (int i = 1; i < 10; i++) add(0,1,i,1, 1,i-1,1,1,0);
    add(0,0,0,1, 1,9,1,1,0);
    add(0,0,0,0, 0,0,1,0,0);
    // full with simultaneous push and pop: no write-through
    add(0,1,1,0, 0,0,1,0,0);
    add(0,1,2,0, 1,1,1,1,0);
    add(0,1,3,0, 1,1,1,2,0);
    add(0,1,4,0, 1,1,1,3,1);
    add(0,1,7,1, 1,1,0,4,1);
    add(0,0,0,0, 1,2,1,3,1);
    // reset mid-operation discards contents
    add(1,1,3,1, 0,0,0,0,0);
    add(0,0,0,0, 0,0,1,0,0);

    foreach (tbl[i]) begin
      reset = tbl[i].rst; v_in = tbl[i].v; data_in = tbl[i].d; r_in = tbl[i].r;
      @(negedge clk);
      check_model($sformatf("model_row%0d", i));
`ifndef HS_FIFO_BYPASS_EN
      cmp($sformatf("row%0d.v_out", i), int'(v_out), int'(tbl[i].ev));
      cmp($sformatf("row%0d.data_out", i), int'(data_out), int'(tbl[i].ed));
      cmp($sformatf("row%0d.r_out", i), int'(r_out), int'(tbl[i].er));
      cmp($sformatf("row%0d.count", i), int'(count), tbl[i].ec);
      cmp($sformatf("row%0d.almost_full", i), int'(almost_full), int'(tbl[i].eaf));
`endif
      @(posedge clk);
      model_update();
      #1;
    end

    // empty FIFO, push 9 with consumer ready
    reset = 1'b0; v_in = 1'b1; data_in = 4'd9; r_in = 1'b1;
    @(negedge clk);
`ifdef HS_FIFO_BYPASS_EN
    cmp("pass.v_out", int'(v_out), 1);
    cmp("pass.data_out", int'(data_out), 9);
`else
    cmp("pass.v_out", int'(v_out), 0);
    cmp("pass.data_out", int'(data_out), 0);
`endif
    @(posedge clk);
    model_update();
    #1;
    v_in = 1'b0; data_in = '0;
    @(negedge clk);
`ifdef HS_FIFO_BYPASS_EN
    cmp("pass_next.v_out", int'(v_out), 0);
    cmp("pass_next.count", int'(count), 0);
`else
    cmp("pass_next.v_out", int'(v_out), 1);
    cmp("pass_next.data_out", int'(data_out), 9);
    cmp("pass_next.count", int'(count), 1);
`endif
    @(posedge clk);
    model_update();
    #1;
    cycle(1'b0, 1'b0, '0, 1'b0, "pass_after");

    // randomized traffic with occasional reset
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 49) == 0), 1'($urandom), WIDTH'($urandom),
            ($urandom_range(0, 3) != 0) ? 1'($urandom) : 1'b0, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
